// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, instruction field positions and controller state shared with the ALU
package alu_pkg;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam int OP_LO  = 12;
    localparam int RD_LO  = 8;
    localparam int RS_LO  = 4;
    localparam int RT_LO  = 0;
    localparam int IMM_LO = 0;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
    function automatic logic is_arith(input logic [3:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two async read ports and one sync write port, r0 fixed at 0
module regfile_2r1w #(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] da,
    output logic [DW-1:0] db,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [DW-1:0] mem [NREGS];

    // clear on reset; writes to r0 are dropped so it always reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign da = ra == '0 ? '0 : mem[ra];
    assign db = rb == '0 ? '0 : mem[rb];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts instructions, issues ADD/SUB to a pipelined ALU and writes results back
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NREGS   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [DW-1:0] instr_data,
    output logic          instr_ready,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          done_valid,
    output logic [3:0]    done_rd,
    output logic [DW-1:0] done_data,
    output logic          zero_flag,
    output logic          illegal
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(ALU_LAT + 1);

    state_t        state;
    logic [3:0]    op_q;
    logic [3:0]    rd_q;
    logic [CW-1:0] cnt;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [3:0]    op;

    assign op          = instr_data[OP_LO +: 4];
    assign instr_ready = state == IDLE;

    regfile_2r1w #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra  (instr_data[RS_LO +: AW]),
        .rb  (instr_data[RT_LO +: AW]),
        .da  (rs_val),
        .db  (rt_val),
        .we  (state == WB),
        .wa  (rd_q[AW-1:0]),
        .wd  (wb_data)
    );

    // issue FSM: decode in IDLE, hold operands for one ISSUE cycle, wait out ALU latency, retire in WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_NOP;
            rd_q       <= '0;
            cnt        <= '0;
            wb_data    <= '0;
            alu_opcode <= OP_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            done_valid <= 1'b0;
            done_rd    <= '0;
            done_data  <= '0;
            zero_flag  <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            illegal    <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    op_q    <= op;
                    rd_q    <= instr_data[RD_LO +: 4];
                    wb_data <= DW'(instr_data[IMM_LO +: 8]);
                    if (op == OP_LDI) begin
                        state <= WB;
                    end else if (is_arith(op)) begin
                        alu_opcode <= op;
                        alu_a      <= rs_val;
                        alu_b      <= rt_val;
                        state      <= ISSUE;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                ISSUE: begin
                    alu_opcode <= OP_NOP;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: if (cnt == CW'(ALU_LAT - 1)) begin
                    wb_data <= alu_result;
                    state   <= WB;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WB: begin
                    done_valid <= 1'b1;
                    done_rd    <= rd_q;
                    done_data  <= wb_data;
                    zero_flag  <= is_arith(op_q) ? wb_data == '0 : zero_flag;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of the issue controller against pipelined ALU models (latency 1 and 3)
module tb_alu_issue_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic        v1 = 0, v3 = 0;
    logic [15:0] d1 = 0, d3 = 0;
    logic        rdy1, rdy3, dv1, dv3, z1, z3, ill1, ill3;
    logic [3:0]  op1, op3, drd1, drd3;
    logic [15:0] a1, b1, a3, b3, res1, res3, dd1, dd3;
    logic [15:0] p1 [1];
    logic [15:0] p3 [3];
    int          cmp = 0;
    int          err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .instr_valid(v1), .instr_data(d1), .instr_ready(rdy1),
        .alu_opcode(op1), .alu_a(a1), .alu_b(b1), .alu_result(res1),
        .done_valid(dv1), .done_rd(drd1), .done_data(dd1), .zero_flag(z1), .illegal(ill1)
    );

    alu_issue_ctrl #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(v3), .instr_data(d3), .instr_ready(rdy3),
        .alu_opcode(op3), .alu_a(a3), .alu_b(b3), .alu_result(res3),
        .done_valid(dv3), .done_rd(drd3), .done_data(dd3), .zero_flag(z3), .illegal(ill3)
    );

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        return op == 4'h2 ? a + b : op == 4'h3 ? a - b : 16'h0;
    endfunction

    always_ff @(posedge clk) p1[0] <= alu_f(op1, a1, b1);
    always_ff @(posedge clk) begin
        p3[0] <= alu_f(op3, a3, b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign res1 = p1[0];
    assign res3 = p3[2];

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic run(input logic [15:0] i, input logic [3:0] erd, input logic [15:0] edata, input int eedge, input logic ez, input string nm);
        int n;
        n = 0;
        cmp++;
        if (rdy1 !== 1'b1) begin err++; $display("FAIL %s ready: got %b want 1", nm, rdy1); end
        v1 = 1; d1 = i;
        @(posedge clk); #1;
        v1 = 0;
        if (i[15:12] == 4'h2 || i[15:12] == 4'h3) begin
            cmp++;
            if (op1 !== i[15:12]) begin err++; $display("FAIL %s issue_op: got %h want %h", nm, op1, i[15:12]); end
        end
        for (int k = 2; k <= 12 && n == 0; k++) begin
            @(posedge clk); #1;
            if (dv1 === 1'b1) n = k;
        end
        cmp++;
        if (n != eedge) begin err++; $display("FAIL %s done_edge: got %0d want %0d", nm, n, eedge); end
        cmp++;
        if (drd1 !== erd || dd1 !== edata) begin err++; $display("FAIL %s done: got r%0d=%h want r%0d=%h", nm, drd1, dd1, erd, edata); end
        cmp++;
        if (z1 !== ez) begin err++; $display("FAIL %s zero_flag: got %b want %b", nm, z1, ez); end
        @(posedge clk); #1;
        cmp++;
        if (dv1 !== 1'b0) begin err++; $display("FAIL %s done_pulse: got %b want 0", nm, dv1); end
    endtask

    task automatic run3(input logic [15:0] i, input logic [3:0] erd, input logic [15:0] edata, input int eedge, input string nm);
        int n;
        n = 0;
        v3 = 1; d3 = i;
        @(posedge clk); #1;
        v3 = 0;
        for (int k = 2; k <= 14 && n == 0; k++) begin
            @(posedge clk); #1;
            if (dv3 === 1'b1) n = k;
        end
        cmp++;
        if (n != eedge) begin err++; $display("FAIL %s done_edge: got %0d want %0d", nm, n, eedge); end
        cmp++;
        if (drd3 !== erd || dd3 !== edata) begin err++; $display("FAIL %s done: got r%0d=%h want r%0d=%h", nm, drd3, dd3, erd, edata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cmp++;
        if ({rdy1, op1, z1, dv1, ill1} !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0})
            begin err++; $display("FAIL reset: got rdy=%b op=%h z=%b dv=%b ill=%b want 1 0 0 0 0", rdy1, op1, z1, dv1, ill1); end
    endtask

    task automatic test_add;
        run({4'h1, 4'd1, 8'h05}, 4'd1, 16'h0005, 2, 1'b0, "ldi_r1");
        run({4'h1, 4'd2, 8'h03}, 4'd2, 16'h0003, 2, 1'b0, "ldi_r2");
        run(ins(4'h2, 4'd3, 4'd1, 4'd2), 4'd3, 16'h0008, 4, 1'b0, "add_r3");
    endtask

    task automatic test_sub_zero;
        run(ins(4'h3, 4'd4, 4'd1, 4'd1), 4'd4, 16'h0000, 4, 1'b1, "sub_zero");
        run({4'h1, 4'd5, 8'h00}, 4'd5, 16'h0000, 2, 1'b1, "ldi_keeps_z");
    endtask

    task automatic test_wrap;
        run(ins(4'h3, 4'd6, 4'd2, 4'd1), 4'd6, 16'hFFFE, 4, 1'b0, "sub_under");
        run({4'h1, 4'd7, 8'hFF}, 4'd7, 16'h00FF, 2, 1'b0, "ldi_ff");
        run(ins(4'h2, 4'd12, 4'd7, 4'd7), 4'd12, 16'h01FE, 4, 1'b0, "add_ff");
        run({4'h1, 4'd9, 8'h01}, 4'd9, 16'h0001, 2, 1'b0, "ldi_one");
        run(ins(4'h3, 4'd10, 4'd0, 4'd9), 4'd10, 16'hFFFF, 4, 1'b0, "sub_ffff");
        run(ins(4'h2, 4'd11, 4'd10, 4'd9), 4'd11, 16'h0000, 4, 1'b1, "add_over");
    endtask

    task automatic test_illegal_r0;
        v1 = 1; d1 = 16'hF1AB;
        @(posedge clk); #1;
        v1 = 0;
        cmp++;
        if (ill1 !== 1'b1 || dv1 !== 1'b0) begin err++; $display("FAIL illegal_pulse: got ill=%b dv=%b want 1 0", ill1, dv1); end
        @(posedge clk); #1;
        cmp++;
        if (ill1 !== 1'b0 || dv1 !== 1'b0 || rdy1 !== 1'b1) begin err++; $display("FAIL illegal_after: got ill=%b dv=%b rdy=%b want 0 0 1", ill1, dv1, rdy1); end
        run(ins(4'h2, 4'd13, 4'd1, 4'd0), 4'd13, 16'h0005, 4, 1'b0, "r1_kept");
        run(ins(4'h2, 4'd0, 4'd1, 4'd2), 4'd0, 16'h0008, 4, 1'b0, "add_r0");
        run(ins(4'h2, 4'd14, 4'd0, 4'd0), 4'd14, 16'h0000, 4, 1'b1, "r0_zero");
    endtask

    task automatic test_reset_mid;
        v1 = 1; d1 = ins(4'h2, 4'd15, 4'd1, 4'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        repeat (2) begin
            @(posedge clk); #1;
            cmp++;
            if (dv1 !== 1'b0) begin err++; $display("FAIL rst_mid_done: got %b want 0", dv1); end
        end
        rst = 0; v1 = 0;
        cmp++;
        if (rdy1 !== 1'b1 || z1 !== 1'b0) begin err++; $display("FAIL rst_mid_state: got rdy=%b z=%b want 1 0", rdy1, z1); end
        run(ins(4'h2, 4'd14, 4'd15, 4'd0), 4'd14, 16'h0000, 4, 1'b1, "rst_no_wb");
        run(ins(4'h2, 4'd14, 4'd1, 4'd2), 4'd14, 16'h0000, 4, 1'b1, "rst_clears");
    endtask

    task automatic test_lat3;
        run3({4'h1, 4'd1, 8'h05}, 4'd1, 16'h0005, 2, "l3_ldi_r1");
        run3({4'h1, 4'd2, 8'h03}, 4'd2, 16'h0003, 2, "l3_ldi_r2");
        run3(ins(4'h2, 4'd3, 4'd1, 4'd2), 4'd3, 16'h0008, 6, "l3_add");
        cmp++;
        if (z3 !== 1'b0) begin err++; $display("FAIL l3_zero: got %b want 0", z3); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_zero;
        test_wrap;
        test_illegal_r0;
        test_reset_mid;
        test_lat3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
